// File: rtl/tex_packer_if.sv
// Handshake and write-port bundle for tex_packer.
//   in_char/in_eol/in_valid/in_ready : character stream with valid/ready handshake
//   mem_we/mem_addr/mem_din          : packed-word write port to the line memory
//   ptr_we/ptr_line/ptr_addr         : per-line start-address table write port
//   lines/overflow                   : completed line count, sticky capacity flag
// master = character source / table consumer, slave = the packer.
interface tex_packer_if #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 6
);
    logic [7:0]        in_char;
    logic              in_eol;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              ptr_we;
    logic [LINE_W-1:0] ptr_line;
    logic [15:0]       ptr_addr;
    logic [LINE_W:0]   lines;
    logic              overflow;

    modport master (
        output in_char, in_eol, in_valid,
        input  in_ready, mem_we, mem_addr, mem_din,
        input  ptr_we, ptr_line, ptr_addr, lines, overflow
    );

    modport slave (
        input  in_char, in_eol, in_valid,
        output in_ready, mem_we, mem_addr, mem_din,
        output ptr_we, ptr_line, ptr_addr, lines, overflow
    );
endinterface

// File: rtl/tex_packer.sv
// Writer side of the packed-ASCII store. Packs a byte stream two characters per
// 16-bit word (high byte first), NUL-terminates each line and emits one
// pointer-table write per line holding the line's start word address.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : tex_packer_if.slave (character handshake, memory and pointer
//            write strobes, line count, sticky overflow)
module tex_packer #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    tex_packer_if.slave  bus
);
    typedef enum logic [1:0] {HI, LO, TERM, FULL} state_t;

    state_t            state;
    logic [ADDR_W:0]   wptr;        // one extra bit: set means memory exhausted
    logic [7:0]        hold;
    logic              line_start;  // next accepted char opens a new line
    logic              mem_full;
    logic              tab_full;

    assign bus.in_ready = (state == HI) || (state == LO);
    assign mem_full     = wptr[ADDR_W];
    assign tab_full     = bus.lines[LINE_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HI;
            wptr         <= '0;
            hold         <= '0;
            line_start   <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.ptr_we   <= 1'b0;
            bus.ptr_line <= '0;
            bus.ptr_addr <= '0;
            bus.lines    <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.ptr_we <= 1'b0;
            case (state)
                HI: begin
                    if (bus.in_valid) begin
                        if (line_start && tab_full) begin
                            bus.overflow <= 1'b1;
                            state        <= FULL;
                        end else if (bus.in_eol && mem_full) begin
                            bus.overflow <= 1'b1;
                            state        <= FULL;
                        end else begin
                            hold <= bus.in_char;
                            if (line_start) begin
                                bus.ptr_we   <= 1'b1;
                                bus.ptr_line <= bus.lines[LINE_W-1:0];
                                bus.ptr_addr <= 16'(wptr);
                            end
                            if (bus.in_eol) begin
                                // odd-length line: NUL rides in the low byte
                                bus.mem_we   <= 1'b1;
                                bus.mem_addr <= wptr[ADDR_W-1:0];
                                bus.mem_din  <= {bus.in_char, 8'h00};
                                wptr         <= wptr + 1'b1;
                                bus.lines    <= bus.lines + 1'b1;
                                line_start   <= 1'b1;
                                state        <= HI;
                            end else begin
                                line_start <= 1'b0;
                                state      <= LO;
                            end
                        end
                    end
                end
                LO: begin
                    if (bus.in_valid) begin
                        if (mem_full) begin
                            bus.overflow <= 1'b1;
                            state        <= FULL;
                        end else begin
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= wptr[ADDR_W-1:0];
                            bus.mem_din  <= {hold, bus.in_char};
                            wptr         <= wptr + 1'b1;
                            state        <= bus.in_eol ? TERM : HI;
                        end
                    end
                end
                TERM: begin
                    // even-length line: dedicated all-NUL terminator word
                    if (mem_full) begin
                        bus.overflow <= 1'b1;
                        state        <= FULL;
                    end else begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= wptr[ADDR_W-1:0];
                        bus.mem_din  <= 16'h0000;
                        wptr         <= wptr + 1'b1;
                        bus.lines    <= bus.lines + 1'b1;
                        line_start   <= 1'b1;
                        state        <= HI;
                    end
                end
                default: state <= FULL;
            endcase
        end
    end
endmodule

// File: tb/tb_tex_packer.sv
// Directed bench for tex_packer: default geometry, a 4-word memory and a
// 2-line table, sharing one clock, reset and character driver.
module tb_tex_packer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tb_char = '0;
    logic       tb_eol = 1'b0;
    logic       tb_valid = 1'b0;
    int         sel = 0;
    logic       rdy;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    tex_packer_if #(.ADDR_W(8), .LINE_W(6)) b0 ();
    tex_packer_if #(.ADDR_W(2), .LINE_W(6)) b1 ();
    tex_packer_if #(.ADDR_W(8), .LINE_W(1)) b2 ();

    tex_packer #(.ADDR_W(8), .LINE_W(6)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    tex_packer #(.ADDR_W(2), .LINE_W(6)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    tex_packer #(.ADDR_W(8), .LINE_W(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b0.in_char = tb_char;
    assign b1.in_char = tb_char;
    assign b2.in_char = tb_char;
    assign b0.in_eol  = tb_eol;
    assign b1.in_eol  = tb_eol;
    assign b2.in_eol  = tb_eol;
    assign b0.in_valid = tb_valid && (sel == 0);
    assign b1.in_valid = tb_valid && (sel == 1);
    assign b2.in_valid = tb_valid && (sel == 2);
    assign rdy = (sel == 0) ? b0.in_ready : (sel == 1) ? b1.in_ready : b2.in_ready;

    // write recorders
    logic [15:0] m0 [256];
    logic [15:0] m1 [4];
    logic [5:0]  pl0 [8];
    logic [15:0] pa0 [8];
    int w0, w1, w2, p0, p2, both0;

    always @(negedge clk) begin
        if (b0.mem_we) begin m0[b0.mem_addr] = b0.mem_din; w0++; end
        if (b0.ptr_we) begin
            if (p0 < 8) begin pl0[p0] = b0.ptr_line; pa0[p0] = b0.ptr_addr; end
            p0++;
        end
        if (b0.mem_we && b0.ptr_we) both0++;
        if (b1.mem_we) begin m1[b1.mem_addr] = b1.mem_din; w1++; end
        if (b2.mem_we) w2++;
        if (b2.ptr_we) p2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) m0[i] = 16'hDEAD;
        for (int i = 0; i < 4; i++) m1[i] = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin pl0[i] = '1; pa0[i] = 16'hDEAD; end
        w0 = 0; w1 = 0; w2 = 0; p0 = 0; p2 = 0; both0 = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 clear_model();
    endtask

    // presents one char, waits (bounded) for acceptance, returns at the next negedge
    task automatic send(input logic [7:0] c, input logic e);
        int n;
        n = 0;
        tb_char = c;
        tb_eol = e;
        tb_valid = 1'b1;
        while (!rdy && n < 20) begin @(negedge clk); n++; end
        if (!rdy) check("accept_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        #1 tb_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clear_model();
        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_we", 32'(b0.mem_we), 32'd0);
        check("rst_ptr_we", 32'(b0.ptr_we), 32'd0);
        check("rst_lines", 32'(b0.lines), 32'd0);
        check("rst_overflow", 32'(b0.overflow), 32'd0);
        check("rst_ready", 32'(b0.in_ready), 32'd1);

        // "ab"+eol
        do_reset();
        sel = 0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        check("term_stall", 32'(rdy), 32'd0);
        tick(2);
        check("ab_w0", 32'(m0[0]), 32'h6162);
        check("ab_w1", 32'(m0[1]), 32'h0000);
        check("ab_wcnt", 32'(w0), 32'd2);
        check("ab_pcnt", 32'(p0), 32'd1);
        check("ab_pline", 32'(pl0[0]), 32'd0);
        check("ab_paddr", 32'(pa0[0]), 32'd0);
        check("ab_lines", 32'(b0.lines), 32'd1);
        check("ab_ready_back", 32'(rdy), 32'd1);

        // "abc"+eol, "x"+eol
        do_reset();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        send(8'h78, 1'b1);
        tick(2);
        check("abc_w0", 32'(m0[0]), 32'h6162);
        check("abc_w1", 32'(m0[1]), 32'h6300);
        check("x_w2", 32'(m0[2]), 32'h7800);
        check("abcx_wcnt", 32'(w0), 32'd3);
        check("abcx_pcnt", 32'(p0), 32'd2);
        check("x_pline", 32'(pl0[1]), 32'd1);
        check("x_paddr", 32'(pa0[1]), 32'd2);
        check("x_both", 32'(both0), 32'd1);
        check("abcx_lines", 32'(b0.lines), 32'd2);

        // "s^2"+eol with idle cycles between chars
        do_reset();
        send(8'h73, 1'b0); tick(1);
        send(8'h5E, 1'b0); tick(1);
        send(8'h32, 1'b1); tick(3);
        check("gap_w0", 32'(m0[0]), 32'h735E);
        check("gap_w1", 32'(m0[1]), 32'h3200);
        check("gap_wcnt", 32'(w0), 32'd2);
        check("gap_lines", 32'(b0.lines), 32'd1);

        // 4-word memory: "abcdefgh"+eol fills it, terminator refused
        do_reset();
        sel = 1;
        send(8'h61, 1'b0); send(8'h62, 1'b0);
        send(8'h63, 1'b0); send(8'h64, 1'b0);
        send(8'h65, 1'b0); send(8'h66, 1'b0);
        send(8'h67, 1'b0); send(8'h68, 1'b1);
        tick(3);
        check("full_wcnt", 32'(w1), 32'd4);
        check("full_w0", 32'(m1[0]), 32'h6162);
        check("full_w3", 32'(m1[3]), 32'h6768);
        check("full_overflow", 32'(b1.overflow), 32'd1);
        check("full_ready", 32'(rdy), 32'd0);
        check("full_lines", 32'(b1.lines), 32'd0);

        // 2-line table: third line's first char refused
        do_reset();
        sel = 2;
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        check("tab_ovf_before", 32'(b2.overflow), 32'd0);
        send(8'h63, 1'b0);
        tick(2);
        check("tab_lines", 32'(b2.lines), 32'd2);
        check("tab_overflow", 32'(b2.overflow), 32'd1);
        check("tab_pcnt", 32'(p2), 32'd2);
        check("tab_wcnt", 32'(w2), 32'd2);
        check("tab_ready", 32'(rdy), 32'd0);

        // reset mid-line, then a fresh line lands at address 0
        do_reset();
        sel = 0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        #1;
        w0 = 0;
        rst_n = 1'b0;
        tick(3);
        check("midrst_wcnt", 32'(w0), 32'd0);
        check("midrst_lines", 32'(b0.lines), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 clear_model();
        send(8'h7A, 1'b1);
        tick(2);
        check("z_w0", 32'(m0[0]), 32'h7A00);
        check("z_wcnt", 32'(w0), 32'd1);
        check("z_paddr", 32'(pa0[0]), 32'd0);
        check("z_lines", 32'(b0.lines), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
